// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache.
// Provides the word type, the default set count, the address overlay
// {tag, idx, bytoff} for the default geometry and the FSM state encoding.
package icache_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned ICACHE_NSETS = 16;
    localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_NSETS);
    localparam int unsigned ICACHE_TAG_W = WORD_W - 2 - ICACHE_IDX_W;

    typedef logic [WORD_W-1:0] word_t;

    // Overlay of a fetch address for the default geometry.
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_frames.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports: CLK, RST (sync, active-high), flush (invalidate all),
//        we/widx/wtag/wdata (single write port),
//        ridx -> rvalid/rtag/rdata (combinational read).
module icache_frames
    import icache_pkg::*;
#(
    parameter int unsigned NSETS = ICACHE_NSETS,
    localparam int unsigned IDX_W = $clog2(NSETS),
    localparam int unsigned TAG_W = WORD_W - 2 - IDX_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  word_t            wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output word_t            rdata
);

    logic [NSETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [NSETS];
    logic [TAG_W-1:0] tag_d  [NSETS];
    word_t            data_q [NSETS];
    word_t            data_d [NSETS];

    // Flush beats a same-cycle write: the line is left invalid.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
        end else if (we) begin
            valid_d[widx] = 1'b1;
            tag_d[widx]   = wtag;
            data_d[widx]  = wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Tag/data need no reset; they are qualified by valid.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rvalid = valid_q[ridx];
    assign rtag   = tag_q[ridx];
    assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache.
// Datapath side: imemREN/imemaddr in, ihit/imemload out (same-cycle hit).
// Memory side:   iREN/iaddr out, iwait/iload in (fill handshake).
// Control:       CLK, RST (sync, active-high), flush (invalidate all).
module icache
    import icache_pkg::*;
#(
    parameter int unsigned NSETS = ICACHE_NSETS
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    input  logic  flush,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
);

    localparam int unsigned IDX_W = $clog2(NSETS);
    localparam int unsigned TAG_W = WORD_W - 2 - IDX_W;

    icache_state_t state_q, state_d;
    word_t         miss_addr_q, miss_addr_d;
    logic          fill_we;
    logic          rvalid;
    logic [TAG_W-1:0] rtag;
    word_t         rdata;
    logic          hit_c;
    logic          unused_bytoff;

    assign unused_bytoff = ^imemaddr[1:0];

    icache_frames #(.NSETS(NSETS)) u_frames (
        .CLK    (CLK),
        .RST    (RST),
        .flush  (flush),
        .we     (fill_we),
        .widx   (miss_addr_q[IDX_W+1:2]),
        .wtag   (miss_addr_q[WORD_W-1:IDX_W+2]),
        .wdata  (iload),
        .ridx   (imemaddr[IDX_W+1:2]),
        .rvalid (rvalid),
        .rtag   (rtag),
        .rdata  (rdata)
    );

    assign hit_c = imemREN && rvalid && (rtag == imemaddr[WORD_W-1:IDX_W+2]);

    // Next state and outputs; hits only ever reported from IDLE.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_we     = 1'b0;
        ihit        = 1'b0;
        imemload    = '0;
        iREN        = 1'b0;
        iaddr       = '0;
        case (state_q)
            IDLE: begin
                ihit     = hit_c;
                imemload = hit_c ? rdata : '0;
                if (!flush && imemREN && !hit_c) begin
                    miss_addr_d = {imemaddr[WORD_W-1:2], 2'b00};
                    state_d     = MISS;
                end
            end
            MISS: begin
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (flush) begin
                    state_d = IDLE;
                end else if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for the icache.
module tb_icache;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks = 0;
    int errors = 0;

    icache #(.NSETS(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .flush    (flush),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Full miss on address a: detect cycle, waits busy cycles, completion, then hit.
    task automatic fill(input logic [31:0] a, input logic [31:0] d, input int waits);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iload = 32'hDEADBEEF;
        #1;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL fill_detect @%h: ihit=%b iREN=%b required ihit=0 iREN=0", a, ihit, iREN);
        end
        step();
        for (int i = 0; i <= waits; i++) begin
            iwait = (i < waits);
            iload = (i < waits) ? 32'hDEADBEEF : d;
            #1;
            checks++;
            if (iREN !== 1'b1 || iaddr !== a || ihit !== 1'b0) begin
                errors++;
                $display("FAIL fill_miss @%h cyc %0d: iREN=%b iaddr=%h ihit=%b required 1 %h 0",
                         a, i, iREN, iaddr, ihit, a);
            end
            step();
        end
        iwait = 1'b1;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== d || iREN !== 1'b0) begin
            errors++;
            $display("FAIL fill_hit @%h: ihit=%b imemload=%h iREN=%b required 1 %h 0",
                     a, ihit, imemload, iREN, d);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b1; iload = '0;
        step(); step();
        RST = 1'b0;
        #1;
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ihit=%b imemload=%h iREN=%b iaddr=%h required all 0",
                     ihit, imemload, iREN, iaddr);
        end
    endtask

    task automatic test_cold_miss();
        fill(32'h0000_0004, 32'h8C22_0000, 3);
    endtask

    task automatic test_hit();
        step();
        imemaddr = 32'h0000_0004;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h8C22_0000 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL hit_repeat: ihit=%b imemload=%h iREN=%b required 1 8c220000 0",
                     ihit, imemload, iREN);
        end
        imemREN = 1'b0;
        #1;
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL hit_no_req: ihit=%b imemload=%h required 0 0", ihit, imemload);
        end
        step();
    endtask

    task automatic test_conflict();
        fill(32'h0000_0000, 32'h1111_1111, 0);
        step();
        fill(32'h0000_0040, 32'h2222_2222, 1);
        step();
        fill(32'h0000_0000, 32'h1111_1111, 2);
        imemREN = 1'b0;
        step();
    endtask

    task automatic test_redirect();
        imemREN = 1'b1; imemaddr = 32'h0000_0010; iwait = 1'b1;
        step();
        imemaddr = 32'h0000_0020;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (iREN !== 1'b1 || iaddr !== 32'h0000_0010 || ihit !== 1'b0) begin
                errors++;
                $display("FAIL redirect_hold cyc %0d: iREN=%b iaddr=%h ihit=%b required 1 00000010 0",
                         i, iREN, iaddr, ihit);
            end
            step();
        end
        iwait = 1'b0; iload = 32'hAAAA_0010;
        #1;
        checks++;
        if (ihit !== 1'b0 || iaddr !== 32'h0000_0010) begin
            errors++;
            $display("FAIL redirect_done: ihit=%b iaddr=%h required 0 00000010", ihit, iaddr);
        end
        step();
        iwait = 1'b1;
        #1;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL redirect_new_miss: ihit=%b iREN=%b required 0 0", ihit, iREN);
        end
        step();
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h0000_0020) begin
            errors++;
            $display("FAIL redirect_second_fetch: iREN=%b iaddr=%h required 1 00000020", iREN, iaddr);
        end
        iwait = 1'b0; iload = 32'hBBBB_0020;
        step();
        iwait = 1'b1;
        imemaddr = 32'h0000_0010;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'hAAAA_0010) begin
            errors++;
            $display("FAIL redirect_line4: ihit=%b imemload=%h required 1 aaaa0010", ihit, imemload);
        end
        imemREN = 1'b0;
        step();
    endtask

    task automatic test_flush();
        fill(32'h0000_0008, 32'h0000_D008, 0);
        step();
        imemaddr = 32'h0000_000C; iwait = 1'b1;
        step();
        flush = 1'b1; iwait = 1'b0; iload = 32'hCCCC_000C;
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h0000_000C) begin
            errors++;
            $display("FAIL flush_in_miss: iREN=%b iaddr=%h required 1 0000000c", iREN, iaddr);
        end
        imemREN = 1'b0;
        step();
        flush = 1'b0; iwait = 1'b1;
        #1;
        checks++;
        if (iREN !== 1'b0 || iaddr !== 32'h0) begin
            errors++;
            $display("FAIL flush_abort: iREN=%b iaddr=%h required 0 0", iREN, iaddr);
        end
        imemREN = 1'b1; imemaddr = 32'h0000_000C;
        #1;
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("FAIL flush_line3: ihit=%b required 0", ihit);
        end
        imemaddr = 32'h0000_0008;
        #1;
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("FAIL flush_refetch8: ihit=%b required 0", ihit);
        end
        imemREN = 1'b0;
        step();
    endtask

    task automatic test_flush_idle();
        fill(32'h0000_0008, 32'h0000_E008, 0);
        flush = 1'b1;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h0000_E008) begin
            errors++;
            $display("FAIL flush_cycle_hit: ihit=%b imemload=%h required 1 0000e008", ihit, imemload);
        end
        imemaddr = 32'h0000_0014;
        #1;
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle_miss: ihit=%b required 0", ihit);
        end
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (iREN !== 1'b0) begin
            errors++;
            $display("FAIL flush_suppress: iREN=%b required 0", iREN);
        end
        imemaddr = 32'h0000_0008;
        #1;
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("FAIL flush_after_idle: ihit=%b required 0", ihit);
        end
        imemREN = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_miss();
        imemREN = 1'b1; imemaddr = 32'h0000_0018; iwait = 1'b1;
        step();
        RST = 1'b1; iwait = 1'b0; iload = 32'h5555_0018;
        step();
        RST = 1'b0; iwait = 1'b1;
        #1;
        checks++;
        if (iREN !== 1'b0 || ihit !== 1'b0 || iaddr !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_miss: iREN=%b ihit=%b iaddr=%h required 0 0 0", iREN, ihit, iaddr);
        end
        step();
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h0000_0018) begin
            errors++;
            $display("FAIL rst_refetch: iREN=%b iaddr=%h required 1 00000018", iREN, iaddr);
        end
        iwait = 1'b0; iload = 32'h6666_0018;
        step();
        iwait = 1'b1;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h6666_0018) begin
            errors++;
            $display("FAIL rst_refill: ihit=%b imemload=%h required 1 66660018", ihit, imemload);
        end
        imemREN = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_redirect();
        test_flush();
        test_flush_idle();
        test_reset_mid_miss();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
